// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N:1 W-bit selector with a registered output stage, valid/ready on every port,
// and fixed-select or round-robin arbitration. Define RR_MUX_PARITY_EN to add out_parity.
module rr_mux_reg #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef RR_MUX_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_IN - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  src_q, src_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              load_en;
  logic              fix_vld;
  logic              rr_vld;
  logic [SEL_W-1:0]  rr_grant;
  logic [SEL_W-1:0]  rr_cand;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant;
  logic              xfer;
  logic [WIDTH-1:0]  grant_word;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

  // A full register that is being drained this cycle can accept a new word at once.
  assign load_en = !out_valid || out_ready;

  assign fix_vld = (int'(sel) < NUM_IN) && in_valid[sel];

  // Round-robin search starts one past the last granted channel and wraps modulo NUM_IN.
  always_comb begin
    rr_vld   = 1'b0;
    rr_grant = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      rr_cand = SEL_W'((int'(ptr_q) + k) % NUM_IN);
      if (!rr_vld && in_valid[rr_cand]) begin
        rr_vld   = 1'b1;
        rr_grant = rr_cand;
      end
    end
  end

  assign grant_vld  = mode ? rr_vld : fix_vld;
  assign grant      = mode ? rr_grant : sel;
  assign xfer       = !reset && load_en && grant_vld;
  assign grant_word = in_data[grant*WIDTH +: WIDTH];
  assign in_ready   = xfer ? (NUM_IN'(1) << grant) : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = FULL;
      data_d  = grant_word;
      src_d   = grant;
      // Fixed-mode transfers leave the fairness pointer where round-robin last left it.
      if (mode) begin
        ptr_d = grant;
      end
    end else if (load_en) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_MUX_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d   = xfer ? ^grant_word : parity_q;
  assign out_parity = parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: randomized and directed checks of rr_mux_reg against a queue-free
// behavioural model of the grant/output rules (parity checked when RR_MUX_PARITY_EN is defined).
module tb_rr_mux_reg;

  localparam int WIDTH  = 4;
  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;
`ifdef RR_MUX_PARITY_EN
  logic                    out_parity;
`endif

  int vectors     = 0;
  int miscompares = 0;

  int         m_ptr   = NUM_IN - 1;
  bit         m_valid = 1'b0;
  logic [3:0] m_data  = '0;
  int         m_src   = 0;
  bit         m_par   = 1'b0;

  always #5 clk = ~clk;

  rr_mux_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .out_data(out_data),
    .out_src(out_src),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef RR_MUX_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  // Reference: which channel the rules say wins right now, or -1 for none.
  function automatic int model_grant();
    if (reset) return -1;
    if (!mode) return (int'(sel) < NUM_IN && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= NUM_IN; k++) begin
      if (in_valid[(m_ptr + k) % NUM_IN]) return (m_ptr + k) % NUM_IN;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_ready();
    int g;
    g = model_grant();
    if (g < 0 || (m_valid && !out_ready)) return 8'h00;
    return 8'(1 << g);
  endfunction

  task automatic model_step();
    int g;
    g = model_grant();
    if (reset) begin
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = NUM_IN - 1; m_par = 0;
    end else if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_src   = g;
        m_par   = ^m_data;
        if (mode) m_ptr = g;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 8'hFF; out_ready = 1; mode = 1; sel = '0; in_data = $urandom;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (in_ready !== 8'h00) begin miscompares++; $display("FAIL reset_ready: got %b want 00000000", in_ready); end
      tick();
    end
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_out: got v=%b d=%h s=%0d want v=0 d=0 s=0", out_valid, out_data, out_src);
    end
    reset = 0;
    #1;
    vectors++;
    if (in_ready !== 8'h01 || in_ready !== model_ready()) begin
      miscompares++; $display("FAIL reset_first_rr: got %b want 00000001", in_ready);
    end
    tick();
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_src !== 3'd0) begin
      miscompares++; $display("FAIL reset_first_src: got v=%b s=%0d want v=1 s=0", out_valid, out_src);
    end
  endtask

  task automatic test_fixed();
    mode = 0; sel = 3'd5; in_valid = 8'b0010_0100; out_ready = 1;
    in_data = $urandom; in_data[5*WIDTH +: WIDTH] = 4'hA;
    #1;
    vectors++;
    if (in_ready !== 8'b0010_0000 || in_ready !== model_ready()) begin
      miscompares++; $display("FAIL fixed_ready: got %b want 00100000", in_ready);
    end
    tick();
    #1;
    vectors++;
    if (out_data !== 4'hA || out_src !== 3'd5 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL fixed_load: got d=%h s=%0d v=%b want d=a s=5 v=1", out_data, out_src, out_valid);
    end
    in_valid = 8'b0000_0100;
    #1;
    vectors++;
    if (in_ready !== 8'h00) begin miscompares++; $display("FAIL fixed_noval_ready: got %b want 00000000", in_ready); end
    tick();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_valid !== m_valid) begin
      miscompares++; $display("FAIL fixed_noload: got v=%b want v=0", out_valid);
    end
    for (int c = 0; c < 24; c++) begin
      sel = 3'($urandom); in_valid = 8'($urandom); in_data = $urandom; out_ready = ($urandom % 4) != 0;
      #1;
      vectors++;
      if (in_ready !== model_ready()) begin
        miscompares++; $display("FAIL fixed_rand_ready: got %b want %b", in_ready, model_ready());
      end
      tick();
      #1;
      vectors++;
      if (out_valid !== m_valid || out_data !== m_data || out_src !== 3'(m_src)) begin
        miscompares++;
        $display("FAIL fixed_rand_out: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
    end
  endtask

  task automatic test_rr_sweep();
    reset = 1; tick(); reset = 0;
    mode = 1; in_valid = 8'hFF; in_data = 32'h7654_3210; out_ready = 1; sel = 3'($urandom);
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++;
      if (in_ready !== model_ready()) begin
        miscompares++; $display("FAIL sweep_ready: got %b want %b", in_ready, model_ready());
      end
      tick();
      #1;
      vectors++;
      if (out_src !== 3'(c % NUM_IN) || out_data !== 4'(c % NUM_IN) || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_out: got s=%0d d=%h want s=%0d d=%0h", out_src, out_data, c % NUM_IN, c % NUM_IN);
      end
    end
  endtask

  task automatic test_skip_wrap();
    int exp_seq[3] = '{0, 2, 0};
    mode = 1; in_valid = 8'h40; out_ready = 1; in_data = $urandom;
    tick();
    in_valid = 8'b0000_0101;
    for (int c = 0; c < 3; c++) begin
      in_data = $urandom;
      #1;
      vectors++;
      if (in_ready !== 8'(1 << exp_seq[c]) || in_ready !== model_ready()) begin
        miscompares++; $display("FAIL wrap_ready: got %b want channel %0d", in_ready, exp_seq[c]);
      end
      tick();
      #1;
      vectors++;
      if (out_src !== 3'(exp_seq[c]) || out_data !== m_data) begin
        miscompares++; $display("FAIL wrap_src: got s=%0d d=%h want s=%0d d=%h", out_src, out_data, exp_seq[c], m_data);
      end
    end
  endtask

  task automatic test_back_pressure();
    mode = 1; out_ready = 1; in_valid = 8'h08; in_data = $urandom; in_data[3*WIDTH +: WIDTH] = 4'h3;
    tick();
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 8'($urandom) | 8'h02; in_data = $urandom;
      #1;
      vectors++;
      if (in_ready !== 8'h00 || out_data !== 4'h3 || out_src !== 3'd3 || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold: got r=%b d=%h s=%0d v=%b want r=0 d=3 s=3 v=1", in_ready, out_data, out_src, out_valid);
      end
      tick();
    end
    out_ready = 1; in_valid = 8'h02; in_data = $urandom; in_data[1*WIDTH +: WIDTH] = 4'h9;
    #1;
    vectors++;
    if (in_ready !== 8'h02) begin miscompares++; $display("FAIL bp_release_ready: got %b want 00000010", in_ready); end
    tick();
    #1;
    vectors++;
    if (out_data !== 4'h9 || out_src !== 3'd1) begin
      miscompares++; $display("FAIL bp_release_out: got d=%h s=%0d want d=9 s=1", out_data, out_src);
    end
  endtask

`ifdef RR_MUX_PARITY_EN
  task automatic test_parity();
    logic [3:0] words[2] = '{4'b1011, 4'b0110};
    bit         pars[2]  = '{1'b1, 1'b0};
    mode = 0; sel = 3'd2; in_valid = 8'h04; out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      in_data = $urandom; in_data[2*WIDTH +: WIDTH] = words[c];
      tick();
      #1;
      vectors++;
      if (out_parity !== pars[c]) begin
        miscompares++; $display("FAIL parity_load: got %b want %b", out_parity, pars[c]);
      end
    end
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 8'($urandom); in_data = $urandom; sel = 3'($urandom);
      tick();
      #1;
      vectors++;
      if (out_parity !== 1'b0) begin miscompares++; $display("FAIL parity_hold: got %b want 0", out_parity); end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom % 32) == 0; mode = 1'($urandom); sel = 3'($urandom);
      in_valid = 8'($urandom); in_data = $urandom; out_ready = ($urandom % 3) != 0;
      #1;
      vectors++;
      if (in_ready !== model_ready()) begin
        miscompares++; $display("FAIL rand_ready: got %b want %b", in_ready, model_ready());
      end
      tick();
      #1;
      vectors++;
      if (out_valid !== m_valid || out_data !== m_data || out_src !== 3'(m_src)) begin
        miscompares++;
        $display("FAIL rand_out: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
`ifdef RR_MUX_PARITY_EN
      vectors++;
      if (out_parity !== m_par) begin miscompares++; $display("FAIL rand_parity: got %b want %b", out_parity, m_par); end
`endif
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_sweep();
    test_skip_wrap();
    test_back_pressure();
`ifdef RR_MUX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
